mult_hilo_unit: RTL and testbench
=================================

// Module: mult_hilo_unit
// PURPOSE
//  Iterative shift-add multiplier that owns the HI/LO register pair of the MIPS datapath.
//  Sits downstream of ALU control: consumes alu_sel_t (C_MULT / C_MUL_U) and the two
//  32-bit operands, then produces the 64-bit product into HI/LO.
//  The main ALU reads hi/lo for C_MFHI / C_MFLO. The controller stalls on busy.
// PARAMETERS
//  WIDTH  32  operand width; product is 2*WIDTH; iteration count = WIDTH
// PORTS
//  clk       in   1      clock, all state on rising edge
//  rst       in   1      reset, asynchronous, active-high
//  start     in   1      request a multiply; qualified by alu_sel
//  alu_sel   in   5      alu_pkg::alu_sel_t; only C_MULT (signed) and C_MUL_U (unsigned) act
//  in0       in   WIDTH  multiplicand (rs)
//  in1       in   WIDTH  multiplier (rt)
//  busy      out  1      high while a multiply is in flight
//  done      out  1      one-cycle pulse: hi/lo just updated
//  hi        out  WIDTH  upper product word (HI register)
//  lo        out  WIDTH  lower product word (LO register)
// BEHAVIOUR
//  - Reset (async, any time): state=M_IDLE; busy=0, done=0, hi=0, lo=0; counter and
//    product register = 0. An in-flight multiply is discarded and done never fires for it.
//  - Accept: at an edge where state==M_IDLE && start && alu_sel in {C_MULT,C_MUL_U}.
//    Any other alu_sel is ignored. start while not in M_IDLE is ignored; operands are
//    not re-latched.
//  - Operand latch on accept:
//    - C_MUL_U: multiplicand=in0, multiplier=in1, neg=0.
//    - C_MULT: magnitudes |in0|, |in1| (two's-complement negate if MSB set; 0x80000000
//      stays 0x80000000, read as unsigned 2^31), neg=in0[W-1]^in1[W-1].
//    - count=0; product reg {carry,P[2W-1:0]} = {0, WIDTH'0, multiplier}.
//  - M_BUSY, one iteration per edge, WIDTH edges: if P[0], add multiplicand into
//    P[2W-1:W] with carry-out. Then shift {carry,P} right by 1 and count++.
//    Leave for M_FINISH after the iteration where count==WIDTH-1.
//  - M_FINISH, one edge: {hi,lo} <= neg ? -P (mod 2^2W) : P; done<=1; state->M_IDLE.
//    A product of zero with neg=1 yields 0.
//  - Timing: accept at edge k; busy=1 after edges k..k+WIDTH; hi/lo update and busy=0 at
//    edge k+WIDTH+1; done=1 for exactly the cycle after edge k+WIDTH+1.
//    Total accept-to-done latency is WIDTH+1 cycles.
//  - hi/lo hold their previous values throughout a multiply; they change only in M_FINISH
//    or on reset.
//  - Back-to-back: state is M_IDLE during the done cycle, so a start in that cycle is
//    accepted (done=1 and busy=1 after that same edge).
//  - busy is a registered output: busy = (state != M_IDLE).
// STRUCTURE
//  - alu_pkg: existing alu_sel_t. Add mult_state_t enum {M_IDLE, M_BUSY, M_FINISH}
//    (2 bits) to the package.
//  - One sub-module: mult_shift_add_dp holds the operand regs, the 2W+1 product register,
//    the adder and the final conditional negate. The top holds the FSM, counter
//    ($clog2(WIDTH) bits) and the hi/lo/done registers.
// TESTING
//  1. Reset: rst pulse mid-cycle -> hi=0, lo=0, busy=0, done=0 immediately (async).
//  2. C_MUL_U 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 cycles
//     after accept; busy high 33 cycles.
//  3. C_MULT 0xFFFFFFFD(-3)*0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then
//     C_MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0x00000000.
//  4. Ignore cases:
//     - start with alu_sel=C_ADD_U -> busy stays 0, hi/lo unchanged.
//     - start with new operands at iteration 5 -> result is that of the original operands.
//  5. Back-to-back: 6*7 (C_MUL_U), then a start in the done cycle with 0*0xFFFFFFFF
//     (C_MULT) -> first lo=42, second hi=lo=0; second done at +33 cycles.
//  6. rst asserted at iteration 10 of 0x12345678*0x9ABCDEF0 -> hi/lo=0, busy=0, no done
//     pulse. A fresh multiply after release produces the correct full result.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control types plus the multiplier FSM state encoding.
package alu_pkg;

    typedef enum logic [4:0] {
        C_ADD   = 5'd0,
        C_ADD_U = 5'd1,
        C_SUB   = 5'd2,
        C_SUB_U = 5'd3,
        C_AND   = 5'd4,
        C_OR    = 5'd5,
        C_XOR   = 5'd6,
        C_NOR   = 5'd7,
        C_SLT   = 5'd8,
        C_SLTU  = 5'd9,
        C_SLL   = 5'd10,
        C_SRL   = 5'd11,
        C_SRA   = 5'd12,
        C_LUI   = 5'd13,
        C_MULT  = 5'd14,
        C_MUL_U = 5'd15,
        C_MFHI  = 5'd16,
        C_MFLO  = 5'd17
    } alu_sel_t;

    typedef enum logic [1:0] {
        M_IDLE   = 2'd0,
        M_BUSY   = 2'd1,
        M_FINISH = 2'd2
    } mult_state_t;

    function automatic logic is_mult_op(alu_sel_t sel);
        return (sel == C_MULT) || (sel == C_MUL_U);
    endfunction

endpackage

// File: rtl/mult_shift_add_dp.sv
// Shift-add datapath: operand magnitudes, the 2W+1 product register with carry,
// and the final conditional negate that restores the sign of a signed product.
module mult_shift_add_dp
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   in0,
    input  logic [WIDTH-1:0]   in1,
    output logic [2*WIDTH-1:0] result
);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic             neg_q, neg_d;
    logic [2*WIDTH:0] prod_q, prod_d;

    logic [WIDTH-1:0] mag0, mag1;
    logic [WIDTH:0]   sum;
    logic [2*WIDTH:0] added;

    // The most negative operand negates to itself, which is exactly its unsigned magnitude.
    assign mag0 = (is_signed && in0[WIDTH-1]) ? WIDTH'(-in0) : in0;
    assign mag1 = (is_signed && in1[WIDTH-1]) ? WIDTH'(-in1) : in1;

    assign sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign added = {sum, prod_q[WIDTH-1:0]};

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path can infer a latch.
        mcand_d = mcand_q;
        neg_d   = neg_q;
        prod_d  = prod_q;
        if (load) begin
            mcand_d = mag0;
            neg_d   = is_signed && (in0[WIDTH-1] ^ in1[WIDTH-1]);
            prod_d  = {1'b0, {WIDTH{1'b0}}, mag1};
        end else if (step) begin
            prod_d = {1'b0, added[2*WIDTH:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registers use non-blocking assignments so all state updates see pre-edge values.
        if (rst) begin
            mcand_q <= '0;
            neg_q   <= 1'b0;
            prod_q  <= '0;
        end else begin
            mcand_q <= mcand_d;
            neg_q   <= neg_d;
            prod_q  <= prod_d;
        end
    end

    assign result = neg_q ? (2*WIDTH)'(-prod_q[2*WIDTH-1:0]) : prod_q[2*WIDTH-1:0];

endmodule

// File: rtl/mult_hilo_unit.sv
// Iterative multiplier owning the HI/LO pair: sequencing FSM, iteration counter,
// and the architectural hi/lo/done registers around the shift-add datapath.
module mult_hilo_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  alu_sel_t         alu_sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    mult_state_t      state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;
    logic             load, step;
    logic [2*WIDTH-1:0] result;

    mult_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .is_signed (alu_sel == C_MULT),
        .in0       (in0),
        .in1       (in1),
        .result    (result)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            M_IDLE: begin
                if (start && is_mult_op(alu_sel)) begin
                    load    = 1'b1;
                    count_d = '0;
                    state_d = M_BUSY;
                end
            end
            M_BUSY: begin
                step    = 1'b1;
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) state_d = M_FINISH;
            end
            M_FINISH: begin
                {hi_d, lo_d} = result;
                done_d       = 1'b1;
                state_d      = M_IDLE;
            end
            default: state_d = M_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= M_IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != M_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Self-checking bench for mult_hilo_unit: vector table plus hand-written corner sequences.
module tb_mult_hilo_unit;
    import alu_pkg::*;

    logic        clk, rst, start;
    alu_sel_t    alu_sel;
    logic [31:0] in0, in1;
    logic        busy, done;
    logic [31:0] hi, lo;

    mult_hilo_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .alu_sel (alu_sel),
        .in0     (in0),
        .in1     (in1),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        alu_sel_t    sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] sb[$];
    logic [63:0] prev_hilo;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(alu_sel_t s, logic [31:0] a, logic [31:0] b);
        logic [63:0] sa, sbv;
        if (s == C_MULT) begin
            sa  = {{32{a[31]}}, a};
            sbv = {{32{b[31]}}, b};
            return $signed(sa) * $signed(sbv);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Called at a negedge with the unit idle; returns at the negedge after the accept edge.
    task automatic launch(input alu_sel_t s, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
        start   = 1'b1;
        alu_sel = s;
        in0     = a;
        in1     = b;
        sb.push_back(exp);
        @(negedge clk);
        start   = 1'b0;
        alu_sel = C_ADD;
        in0     = $urandom;
        in1     = $urandom;
    endtask

    // Waits for done; optionally re-issues start with fresh operands at cycle poke_at.
    task automatic wait_done(input string tag, input int poke_at);
        int          cycles   = 0;
        int          busy_cnt = 0;
        logic        hold_ok  = 1'b1;
        logic [63:0] exp;
        while (!done && cycles < 100) begin
            if (busy) busy_cnt++;
            if ({hi, lo} !== prev_hilo) hold_ok = 1'b0;
            @(negedge clk);
            cycles++;
            if (cycles == poke_at) begin
                start   = 1'b1;
                alu_sel = C_MULT;
                in0     = 32'h0000_0003;
                in1     = 32'h0000_0005;
            end else begin
                start   = 1'b0;
                alu_sel = C_ADD;
            end
        end
        check({tag, " done_seen"}, 64'(done), 64'd1);
        check({tag, " latency"}, 64'(cycles), 64'd33);
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
        check({tag, " hilo_hold"}, 64'(hold_ok), 64'd1);
        check({tag, " busy_at_done"}, 64'(busy), 64'd0);
        if (sb.size() == 0) begin
            check({tag, " scoreboard_empty"}, 64'd1, 64'd0);
        end else begin
            exp = sb.pop_front();
            check({tag, " hilo"}, {hi, lo}, exp);
            prev_hilo = exp;
        end
    endtask

    vec_t vt[10];

    initial begin
        int pulses;
        int busy_seen;

        rst       = 1'b1;
        start     = 1'b0;
        alu_sel   = C_ADD;
        in0       = '0;
        in1       = '0;
        prev_hilo = '0;

        vt[0] = '{C_MUL_U, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vt[1] = '{C_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB};
        vt[2] = '{C_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vt[3] = '{C_MUL_U, 32'h0000_0006, 32'h0000_0007, 64'h0000_0000_0000_002A};
        vt[4] = '{C_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        vt[5] = '{C_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000};
        vt[6] = '{C_MUL_U, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};
        vt[7] = '{C_MULT,  32'h0000_0000, 32'hFFFF_FFFF, 64'h0000_0000_0000_0000};
        vt[8].sel = C_MULT;  vt[8].a = $urandom; vt[8].b = $urandom;
        vt[8].exp = model(vt[8].sel, vt[8].a, vt[8].b);
        vt[9].sel = C_MUL_U; vt[9].a = $urandom; vt[9].b = $urandom;
        vt[9].exp = model(vt[9].sel, vt[9].a, vt[9].b);

        repeat (2) @(negedge clk);
        check("reset hilo", {hi, lo}, 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            launch(vt[i].sel, vt[i].a, vt[i].b, vt[i].exp);
            wait_done($sformatf("vec%0d", i), -1);
            @(negedge clk);
            check($sformatf("vec%0d done_pulse", i), 64'(done), 64'd0);
        end

        // Asynchronous reset asserted mid-cycle, well away from any rising edge.
        #2 rst = 1'b1;
        #1;
        check("async_rst hilo", {hi, lo}, 64'd0);
        check("async_rst busy", 64'(busy), 64'd0);
        check("async_rst done", 64'(done), 64'd0);
        prev_hilo = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Give hi/lo a known nonzero value, then try a non-multiply start.
        launch(C_MUL_U, 32'h0000_1234, 32'h0001_0000, 64'h0000_0000_1234_0000);
        wait_done("preload", -1);
        @(negedge clk);
        start   = 1'b1;
        alu_sel = C_ADD_U;
        in0     = 32'h0000_0009;
        in1     = 32'h0000_0009;
        @(negedge clk);
        start   = 1'b0;
        alu_sel = C_ADD;
        check("ignore_sel busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check("ignore_sel busy_later", 64'(busy), 64'd0);
        check("ignore_sel hilo", {hi, lo}, prev_hilo);

        // A second start at iteration 5 must not disturb the multiply in flight.
        launch(C_MUL_U, 32'h0001_0001, 32'h0000_0100, 64'h0000_0000_0100_0100);
        wait_done("poke_iter5", 5);
        @(negedge clk);
        check("poke_iter5 idle_after", 64'(busy), 64'd0);

        // Back-to-back: the second start is driven during the done cycle.
        launch(C_MUL_U, 32'h0000_0006, 32'h0000_0007, 64'd42);
        wait_done("b2b_first", -1);
        launch(C_MULT, 32'h0000_0000, 32'hFFFF_FFFF, 64'd0);
        wait_done("b2b_second", -1);
        @(negedge clk);

        // Reset at iteration 10 discards the multiply and suppresses its done pulse.
        launch(C_MUL_U, 32'h1234_5678, 32'h9ABC_DEF0, model(C_MUL_U, 32'h1234_5678, 32'h9ABC_DEF0));
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_iter10 hilo", {hi, lo}, 64'd0);
        check("rst_iter10 busy", 64'(busy), 64'd0);
        void'(sb.pop_front());
        prev_hilo = '0;
        @(negedge clk);
        rst       = 1'b0;
        pulses    = 0;
        busy_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) pulses++;
            if (busy) busy_seen++;
        end
        check("rst_iter10 no_done", 64'(pulses), 64'd0);
        check("rst_iter10 stays_idle", 64'(busy_seen), 64'd0);
        launch(C_MUL_U, 32'h1234_5678, 32'h9ABC_DEF0, model(C_MUL_U, 32'h1234_5678, 32'h9ABC_DEF0));
        wait_done("after_rst", -1);
        @(negedge clk);

        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
